// File: rtl/t01_mem_req_pkg.sv
// Shared types and width codes for the memory request arbiter.
package t01_mem_req_pkg;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INSTR,
    REQ_DREAD,
    REQ_DWRITE
  } req_kind_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone,
    StResp
  } arb_state_t;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

endpackage

// File: rtl/t01_lane_formatter.sv
// Byte-lane enables and lane-replicated write data from access width and address offset.
module t01_lane_formatter
  import t01_mem_req_pkg::*;
(
  input  logic        i_is_read,
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_dat
);

  always_comb begin
    o_sel = 4'b1111;
    o_dat = i_data;
    case (i_width)
      WIDTH_BYTE: begin
        o_sel = 4'b0001 << i_addr_lo;
        o_dat = {4{i_data[7:0]}};
      end
      WIDTH_HALF: begin
        // Misaligned halfwords keep the lane pair chosen by addr[1]; no trap.
        o_sel = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_dat = {2{i_data[15:0]}};
      end
      default: ;
    endcase
    if (i_is_read) begin
      o_sel = 4'b1111;
    end
  end

endmodule

// File: rtl/t01_mem_request_arbiter.sv
// Single-master bus front end: arbitrates data/instruction requests onto one Wishbone manager.
// Optional one-entry fetch buffer is enabled by defining T01_IFETCH_CACHE_EN.
module t01_mem_request_arbiter
  import t01_mem_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned BUSY_START_WAIT = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        InstrRead,
  input  logic [31:0] InstrAddress,
  input  logic        DataRead,
  input  logic        DataWrite,
  input  logic [31:0] DataAddress,
  input  logic [31:0] DataToWrite,
  input  logic [1:0]  DataWidth,
  input  logic        busy_o,
  input  logic [31:0] cpu_dat_o,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] FetchedInstr,
  output logic [31:0] FetchedData,
  output logic        read_i,
  output logic        write_i,
  output logic [31:0] adr_i,
  output logic [31:0] cpu_dat_i,
  output logic [3:0]  sel_i,
  output logic        bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StartLast   = CntW'(BUSY_START_WAIT - 1);

  arb_state_t      r_state, w_state_d;
  req_kind_t       r_kind, w_grant_kind;
  logic [31:0]     r_addr, r_data;
  logic [1:0]      r_width;
  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic [31:0]     r_fetched_instr, r_fetched_data;
  logic            w_timeout, w_bus_done, w_waiting, w_drive;
  logic            w_cache_hit;
  logic [31:0]     w_cache_data;
  logic [3:0]      w_sel;
  logic [31:0]     w_dat;

  always_comb begin
    w_grant_kind = REQ_NONE;
    if (DataWrite) begin
      w_grant_kind = REQ_DWRITE;
    end else if (DataRead) begin
      w_grant_kind = REQ_DREAD;
    end else if (InstrRead) begin
      w_grant_kind = REQ_INSTR;
    end
  end

  assign w_waiting = (r_state == StWaitStart) || (r_state == StWaitDone);

  always_comb begin
    w_state_d  = r_state;
    w_timeout  = 1'b0;
    w_bus_done = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_cache_hit) begin
          w_state_d = StResp;
        end else if (w_grant_kind != REQ_NONE) begin
          w_state_d = StIssue;
        end
      end
      StIssue: w_state_d = StWaitStart;
      StWaitStart: begin
        if (busy_o) begin
          w_state_d = StWaitDone;
        end else if (r_cnt == StartLast) begin
          w_state_d = StResp;
        end
      end
      StWaitDone: begin
        if (!busy_o) begin
          w_state_d  = StResp;
          w_bus_done = 1'b1;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // One counter spans both wait states; a normal completion on the last cycle wins.
    if (w_waiting && (w_state_d != StResp) && (r_cnt == TimeoutLast)) begin
      w_state_d = StResp;
      w_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_kind          <= REQ_NONE;
      r_addr          <= '0;
      r_data          <= '0;
      r_width         <= WIDTH_WORD;
      r_cnt           <= '0;
      r_err           <= 1'b0;
      r_fetched_instr <= '0;
      r_fetched_data  <= '0;
    end else begin
      r_err <= w_timeout;
      r_cnt <= (w_waiting && (w_state_d != StResp)) ? r_cnt + 1'b1 : '0;
      if ((r_state == StIdle) && (w_grant_kind != REQ_NONE)) begin
        r_kind  <= w_grant_kind;
        r_addr  <= (w_grant_kind == REQ_INSTR) ? InstrAddress : DataAddress;
        r_data  <= DataToWrite;
        r_width <= (w_grant_kind == REQ_DWRITE) ? DataWidth : WIDTH_WORD;
      end
      if (w_cache_hit) begin
        r_fetched_instr <= w_cache_data;
      end
      if (w_bus_done || w_timeout) begin
        if (r_kind == REQ_INSTR) begin
          r_fetched_instr <= w_timeout ? 32'h0 : cpu_dat_o;
        end else if (r_kind == REQ_DREAD) begin
          r_fetched_data <= w_timeout ? 32'h0 : cpu_dat_o;
        end
      end
    end
  end

`ifdef T01_IFETCH_CACHE_EN
  logic        r_c_valid;
  logic [29:0] r_c_tag;
  logic [31:0] r_c_data;

  assign w_cache_hit  = (r_state == StIdle) && (w_grant_kind == REQ_INSTR) && r_c_valid &&
                        (r_c_tag == InstrAddress[31:2]);
  assign w_cache_data = r_c_data;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_c_valid <= 1'b0;
      r_c_tag   <= '0;
      r_c_data  <= '0;
    end else if ((r_state == StIdle) && (w_grant_kind == REQ_DWRITE) &&
                 (DataAddress[31:2] == r_c_tag)) begin
      r_c_valid <= 1'b0;
    end else if (w_bus_done && (r_kind == REQ_INSTR)) begin
      r_c_valid <= 1'b1;
      r_c_tag   <= r_addr[31:2];
      r_c_data  <= cpu_dat_o;
    end
  end
`else
  assign w_cache_hit  = 1'b0;
  assign w_cache_data = 32'h0;
`endif

  t01_lane_formatter u_lane_formatter (
    .i_is_read (r_kind != REQ_DWRITE),
    .i_width   (r_width),
    .i_addr_lo (r_addr[1:0]),
    .i_data    (r_data),
    .o_sel     (w_sel),
    .o_dat     (w_dat)
  );

  assign w_drive = (r_state == StIssue) || w_waiting;

  assign read_i       = (r_state == StIssue) && (r_kind != REQ_DWRITE);
  assign write_i      = (r_state == StIssue) && (r_kind == REQ_DWRITE);
  assign adr_i        = w_drive ? {r_addr[31:2], 2'b00} : 32'h0;
  assign sel_i        = w_drive ? w_sel : 4'h0;
  assign cpu_dat_i    = w_drive ? w_dat : 32'h0;
  assign ihit         = (r_state == StResp) && (r_kind == REQ_INSTR);
  assign dhit         = (r_state == StResp) &&
                        ((r_kind == REQ_DREAD) || (r_kind == REQ_DWRITE));
  assign bus_err      = (r_state == StResp) && r_err;
  assign FetchedInstr = r_fetched_instr;
  assign FetchedData  = r_fetched_data;

endmodule

// File: tb/tb_t01_mem_request_arbiter.sv
// Self-checking bench: directed and random requests against a transaction-level model.
module tb_t01_mem_request_arbiter;

  localparam int unsigned TO  = 64;
  localparam int unsigned BSW = 4;

  logic        clk = 1'b0;
  logic        nRST;
  logic        InstrRead, DataRead, DataWrite;
  logic [31:0] InstrAddress, DataAddress, DataToWrite;
  logic [1:0]  DataWidth;
  logic        busy_o;
  logic [31:0] cpu_dat_o;
  logic        ihit, dhit, read_i, write_i, bus_err;
  logic [31:0] FetchedInstr, FetchedData, adr_i, cpu_dat_i;
  logic [3:0]  sel_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_fi, exp_fd, r_idata, r_ddata;

  t01_mem_request_arbiter #(
    .TIMEOUT_CYCLES  (TO),
    .BUSY_START_WAIT (BSW)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .InstrRead    (InstrRead),
    .InstrAddress (InstrAddress),
    .DataRead     (DataRead),
    .DataWrite    (DataWrite),
    .DataAddress  (DataAddress),
    .DataToWrite  (DataToWrite),
    .DataWidth    (DataWidth),
    .busy_o       (busy_o),
    .cpu_dat_o    (cpu_dat_o),
    .ihit         (ihit),
    .dhit         (dhit),
    .FetchedInstr (FetchedInstr),
    .FetchedData  (FetchedData),
    .read_i       (read_i),
    .write_i      (write_i),
    .adr_i        (adr_i),
    .cpu_dat_i    (cpu_dat_i),
    .sel_i        (sel_i),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_sel(input logic [1:0] w, input logic [31:0] a, input bit rd);
    int lane;
    lane = int'(a % 4);
    if (rd || w >= 2) return 4'hF;
    if (w == 0) return 4'(1 << lane);
    return 4'(3 << ((lane / 2) * 2));
  endfunction

  function automatic logic [31:0] m_dat(input logic [1:0] w, input logic [31:0] d);
    if (w == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (w == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({read_i, write_i, ihit, dhit, bus_err, sel_i}), 32'h0);
    check({tag, "_adr"}, adr_i, 32'h0);
    check({tag, "_wdat"}, cpu_dat_i, 32'h0);
    check({tag, "_finstr"}, FetchedInstr, 32'h0);
    check({tag, "_fdata"}, FetchedData, 32'h0);
  endtask

  // blen: bus busy cycles after the strobe; 0 = bus never answers; negative = busy forever.
  task automatic run_reqs(input bit want_i, input bit want_r, input bit want_w, input int blen);
    bit          pi, pr, pw;
    int          cyc, k_strobe, exp_strobe, cur, n, lat, ek;
    logic [31:0] ea;
    pi = want_i;
    pr = want_r;
    pw = want_w;
    InstrRead  = pi;
    DataRead   = pr;
    DataWrite  = pw;
    cyc        = 0;
    cur        = 0;
    k_strobe   = 0;
    exp_strobe = 1;
    lat = (blen < 0) ? int'(TO) + 1 : ((blen == 0) ? int'(BSW) + 1 : blen + 2);
    while ((pi || pr || pw) && cyc < 4 * int'(TO) + 40) begin
      @(negedge clk);
      cyc++;
      if (read_i || write_i) begin
        ek = pw ? 3 : (pr ? 2 : 1);
        ea = (ek == 1) ? InstrAddress : DataAddress;
        check("single_outstanding", cur, 0);
        check("strobe_cycle", cyc, exp_strobe);
        check("strobe_kind", 32'({read_i, write_i}), (ek == 3) ? 1 : 2);
        check("adr_i", adr_i, ea & 32'hFFFF_FFFC);
        check("sel_i", 32'(sel_i), 32'(m_sel((ek == 3) ? DataWidth : 2'b10, ea, ek != 3)));
        if (ek == 3) check("cpu_dat_i", cpu_dat_i, m_dat(DataWidth, DataToWrite));
        cur      = ek;
        k_strobe = cyc;
      end else if (cur != 0 && cyc == k_strobe + 1) begin
        check("adr_hold", adr_i, ((cur == 1) ? InstrAddress : DataAddress) & 32'hFFFF_FFFC);
      end
      if (ihit || dhit) begin
        check("hit_kind", 32'({ihit, dhit}), (cur == 1) ? 2 : ((cur == 0) ? 0 : 1));
        check("hit_latency", cyc - k_strobe, lat);
        check("bus_err", 32'(bus_err), 32'(blen < 0));
        if (blen < 0) begin
          if (cur == 1) exp_fi = 32'h0;
          if (cur == 2) exp_fd = 32'h0;
        end else if (blen > 0) begin
          if (cur == 1) exp_fi = r_idata;
          if (cur == 2) exp_fd = r_ddata;
        end
        check("FetchedInstr", FetchedInstr, exp_fi);
        check("FetchedData", FetchedData, exp_fd);
        if (cur == 1) pi = 1'b0;
        else if (cur == 2) pr = 1'b0;
        else if (cur == 3) pw = 1'b0;
        InstrRead  = pi;
        DataRead   = pr;
        DataWrite  = pw;
        cur        = 0;
        exp_strobe = cyc + 2;
      end else if (bus_err) begin
        check("bus_err_stray", 32'(bus_err), 32'h0);
      end
      if (cur != 0) begin
        n         = cyc - k_strobe;
        busy_o    = (blen < 0) || (n >= 1 && n <= blen);
        cpu_dat_o = (blen >= 0 && n >= blen + 1) ? ((cur == 1) ? r_idata : r_ddata) : $urandom;
      end else begin
        busy_o    = 1'b0;
        cpu_dat_o = $urandom;
      end
    end
    check("all_served", 32'({pi, pr, pw}), 32'h0);
    @(negedge clk);
    check("hit_one_cycle", 32'({ihit, dhit}), 32'h0);
  endtask

  initial begin
    int m, hits;
    nRST = 1'b1;
    InstrRead = 1'b0; DataRead = 1'b0; DataWrite = 1'b0;
    InstrAddress = '0; DataAddress = '0; DataToWrite = '0; DataWidth = '0;
    busy_o = 1'b0; cpu_dat_o = '0;
    exp_fi = '0; exp_fd = '0; r_idata = '0; r_ddata = '0;
    #2 nRST = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    InstrAddress = 32'h3300_0400; r_idata = 32'h0050_0093;
    run_reqs(1'b1, 1'b0, 1'b0, 2);
    check("fetch_word", FetchedInstr, 32'h0050_0093);

    DataAddress = 32'h3300_0202; DataToWrite = 32'h41; DataWidth = 2'b00;
    run_reqs(1'b0, 1'b0, 1'b1, 1);

    InstrAddress = 32'h3300_0800; r_idata = 32'h1234_5678;
    DataAddress = 32'h3300_0010; r_ddata = 32'hCAFE_F00D;
    run_reqs(1'b1, 1'b1, 1'b0, 3);

    DataAddress = 32'h3300_0013; DataToWrite = 32'h1234_ABCD; DataWidth = 2'b01;
    r_ddata = 32'h0BAD_BEEF;
    run_reqs(1'b0, 1'b1, 1'b1, 1);

    DataAddress = 32'h3300_0021; DataWidth = 2'b01;
    run_reqs(1'b0, 1'b0, 1'b1, 2);

    DataAddress = 32'h3300_0030; r_ddata = 32'h7777_7777;
    run_reqs(1'b0, 1'b1, 1'b0, 0);

    r_ddata = 32'hDEAD_0001;
    run_reqs(1'b0, 1'b1, 1'b0, -1);
    check("timeout_data_zero", FetchedData, 32'h0);
    r_ddata = 32'h5555_AAAA;
    run_reqs(1'b0, 1'b1, 1'b0, 2);

    for (int i = 0; i < 24; i++) begin
      m            = int'($urandom_range(1, 7));
      InstrAddress = $urandom & 32'hFFFF_FFFC;
      DataAddress  = $urandom;
      DataToWrite  = $urandom;
      DataWidth    = 2'($urandom_range(0, 3));
      r_idata      = $urandom;
      r_ddata      = $urandom;
      run_reqs(m[0], m[1], m[2], int'($urandom_range(0, 5)));
    end

    DataAddress = 32'h3300_0040; DataRead = 1'b1; busy_o = 1'b1;
    repeat (5) @(negedge clk);
    nRST = 1'b0;
    #1;
    check_all_zero("reset_mid");
    exp_fi = '0; exp_fd = '0;
    DataRead = 1'b0; busy_o = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (ihit || dhit) hits++;
    end
    check("no_hit_after_reset", hits, 0);
    InstrAddress = 32'h3300_0C00; r_idata = 32'h0000_0013;
    run_reqs(1'b1, 1'b0, 1'b0, 1);

`ifdef T01_IFETCH_CACHE_EN
    InstrAddress = 32'h3300_0100; r_idata = 32'h0010_0113;
    run_reqs(1'b1, 1'b0, 1'b0, 1);
    InstrRead = 1'b1;
    @(negedge clk);
    check("cache_hit_no_bus", 32'({ihit, read_i}), 32'h2);
    check("cache_hit_data", FetchedInstr, 32'h0010_0113);
    InstrRead = 1'b0;
    @(negedge clk);
    check("cache_hit_one_cycle", 32'(ihit), 32'h0);
    DataAddress = 32'h3300_0100; DataWidth = 2'b10; DataToWrite = 32'h0020_0193;
    run_reqs(1'b0, 1'b0, 1'b1, 1);
    r_idata = 32'h0020_0193;
    run_reqs(1'b1, 1'b0, 1'b0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
